// File: rtl/ctrl_pkg.sv
// Shared ISA constants and control-word type for the 8-bit processor decoder.
package ctrl_pkg;

    localparam logic [3:0] OP_ST  = 4'b0000;
    localparam logic [3:0] OP_LDI = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_JE  = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_JNE = 4'b0101;
    localparam logic [3:0] OP_JC  = 4'b0110;
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_INC = 4'b1010;
    localparam logic [3:0] OP_DEC = 4'b1011;
    localparam logic [3:0] OP_NOP = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_INC = 3'b010;
    localparam logic [2:0] ALU_DEC = 3'b011;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       en_jmp;
        logic       we_mem;
        logic       ld_mem;
        logic       we_reg;
        logic       en_immediate;
    } ctrl_t;

endpackage

// File: rtl/cpu_controller_if.sv
// Instruction/flag inputs and control strobes between the fetch/datapath side and the decoder.
interface cpu_controller_if;

    logic [3:0] opcode;
    logic       flag_carry;
    logic       flag_zero;
    logic [2:0] alu_op;
    logic       en_jmp;
    logic       we_mem;
    logic       ld_mem;
    logic       we_reg;
    logic       en_immediate;

    modport master (
        output opcode, flag_carry, flag_zero,
        input  alu_op, en_jmp, we_mem, ld_mem, we_reg, en_immediate
    );

    modport slave (
        input  opcode, flag_carry, flag_zero,
        output alu_op, en_jmp, we_mem, ld_mem, we_reg, en_immediate
    );

endinterface

// File: rtl/controller_branch_eval.sv
// Raw jump condition from opcode and ALU flags; zero for every non-branch opcode.
module controller_branch_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       flag_carry,
    input  logic       flag_zero,
    output logic       jmp_cond
);

    always_comb begin
        jmp_cond = 1'b0;
        case (opcode)
            OP_JE:   jmp_cond = flag_zero;
            OP_JMP:  jmp_cond = 1'b1;
            OP_JNE:  jmp_cond = ~flag_zero;
            OP_JC:   jmp_cond = flag_carry;
            default: jmp_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Combinational opcode decoder; all strobes gated by a run register cleared on reset.
module cpu_controller
    import ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] opcode_i,
    input  logic       flag_carry,
    input  logic       flag_zero,
    output logic [2:0] alu_op_o,
    output logic       en_jmp_o,
    output logic       we_mem_o,
    output logic       ld_mem_o,
    output logic       we_reg_o,
    output logic       en_immediate_o
);

    logic  run_d;
    logic  run_q;
    logic  jmp_cond;
    ctrl_t dec;
    ctrl_t gated;

    controller_branch_eval u_branch_eval (
        .opcode     (opcode_i),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero),
        .jmp_cond   (jmp_cond)
    );

    always_comb begin
        dec        = '0;
        dec.en_jmp = jmp_cond;
        case (opcode_i)
            OP_ST:  dec.we_mem = 1'b1;
            OP_LDI: begin
                dec.we_reg       = 1'b1;
                dec.en_immediate = 1'b1;
            end
            OP_LD: begin
                dec.ld_mem = 1'b1;
                dec.we_reg = 1'b1;
            end
            OP_ADD: begin
                dec.alu_op = ALU_ADD;
                dec.we_reg = 1'b1;
            end
            OP_SUB: begin
                dec.alu_op = ALU_SUB;
                dec.we_reg = 1'b1;
            end
            OP_INC: begin
                dec.alu_op = ALU_INC;
                dec.we_reg = 1'b1;
            end
            OP_DEC: begin
                dec.alu_op = ALU_DEC;
                dec.we_reg = 1'b1;
            end
            // Jumps, NOP and unassigned opcodes leave only the branch-eval result.
            default: ;
        endcase
    end

    always_comb begin
        run_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) run_q <= 1'b0;
        else       run_q <= run_d;
    end

    always_comb begin
        gated = run_q ? dec : '0;
    end

    assign alu_op_o       = gated.alu_op;
    assign en_jmp_o       = gated.en_jmp;
    assign we_mem_o       = gated.we_mem;
    assign ld_mem_o       = gated.ld_mem;
    assign we_reg_o       = gated.we_reg;
    assign en_immediate_o = gated.en_immediate;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: expected control words queued on drive, compared on sample.
module tb_cpu_controller;

    logic clk;
    logic rst;
    logic exp_run;
    int   n_checks;
    int   n_fail;
    logic [7:0] sb[$];

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .opcode_i       (bus.opcode),
        .flag_carry     (bus.flag_carry),
        .flag_zero      (bus.flag_zero),
        .alu_op_o       (bus.alu_op),
        .en_jmp_o       (bus.en_jmp),
        .we_mem_o       (bus.we_mem),
        .ld_mem_o       (bus.ld_mem),
        .we_reg_o       (bus.we_reg),
        .en_immediate_o (bus.en_immediate)
    );

    wire [7:0] got = {bus.alu_op, bus.en_jmp, bus.we_mem, bus.ld_mem, bus.we_reg, bus.en_immediate};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected run state: set by any edge that samples reset low, cleared by one that samples it high.
    always @(posedge clk) exp_run <= ~rst;

    // Reference opcode table, bit order {alu_op[2:0], jmp, we_mem, ld_mem, we_reg, imm}.
    function automatic logic [7:0] ref_word(input logic [3:0] op, input logic c, input logic z, input logic run);
        logic [7:0] w;
        case (op)
            4'b0000: w = 8'b000_0_1_0_0_0;
            4'b0001: w = 8'b000_0_0_0_1_1;
            4'b0010: w = 8'b000_0_0_1_1_0;
            4'b0011: w = {3'b000, z, 4'b0000};
            4'b0100: w = 8'b000_1_0_0_0_0;
            4'b0101: w = {3'b000, ~z, 4'b0000};
            4'b0110: w = {3'b000, c, 4'b0000};
            4'b1000: w = 8'b000_0_0_0_1_0;
            4'b1001: w = 8'b001_0_0_0_1_0;
            4'b1010: w = 8'b010_0_0_0_1_0;
            4'b1011: w = 8'b011_0_0_0_1_0;
            default: w = 8'b0;
        endcase
        return run ? w : 8'b0;
    endfunction

    task automatic drive(input logic [3:0] op, input logic c, input logic z);
        bus.opcode     = op;
        bus.flag_carry = c;
        bus.flag_zero  = z;
        sb.push_back(ref_word(op, c, z, exp_run));
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0001, 1'b0, 1'b0);
        void'(sb.pop_back());
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (got !== 8'h00) begin n_fail++; $display("FAIL reset_held got=%b exp=%b", got, 8'h00); end
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0001, 1'b0, 1'b0);
        #1;
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_release_before_edge got=%b exp=%b", got, exp); end
        @(posedge clk);
        #1;
        exp = ref_word(4'b0001, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (got !== exp || exp !== 8'b000_0_0_0_1_1) begin
            n_fail++; $display("FAIL reset_release_ldi got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] ops[12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};
        logic [7:0] exp;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(ops[i], 1'b0, 1'b0);
            #1;
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL sweep op=%b got=%b exp=%b", ops[i], got, exp); end
            n_checks++;
            if ((bus.we_mem & bus.we_reg) !== 1'b0 || (bus.ld_mem & bus.en_immediate) !== 1'b0) begin
                n_fail++; $display("FAIL exclusive_strobes op=%b got=%b exp=no_overlap", ops[i], got);
            end
        end
    endtask

    task automatic test_cond_jumps();
        logic [7:0] exp;
        for (int op = 3; op <= 6; op++) begin
            for (int f = 0; f < 4; f++) begin
                @(negedge clk);
                drive(4'(op), f[1], f[0]);
                #1;
                exp = sb.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL cond_jump op=%0d c=%0d z=%0d got=%b exp=%b", op, f[1], f[0], got, exp);
                end
            end
        end
    endtask

    task automatic test_flag_independence();
        logic [3:0] ops[3] = '{4'b1000, 4'b0000, 4'b1111};
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            for (int f = 0; f < 4; f++) begin
                @(negedge clk);
                drive(ops[i], f[1], f[0]);
                #1;
                exp = sb.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL flag_indep op=%b flags=%0d got=%b exp=%b", ops[i], f, got, exp);
                end
            end
        end
    endtask

    task automatic test_unassigned();
        logic [3:0] ops[5] = '{4'b0111, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        logic [7:0] exp;
        for (int i = 0; i < 5; i++) begin
            for (int f = 0; f < 4; f++) begin
                @(negedge clk);
                drive(ops[i], f[1], f[0]);
                #1;
                exp = sb.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL unassigned op=%b flags=%0d got=%b exp=%b", ops[i], f, got, exp);
                end
            end
        end
    endtask

    task automatic test_midrun_reset();
        logic [7:0] exp;
        @(negedge clk);
        drive(4'b0000, 1'b0, 1'b0);
        #1;
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL midrun_before got=%b exp=%b", got, exp); end
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0000, 1'b0, 1'b0);
        #1;
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL midrun_rst_not_sampled got=%b exp=%b", got, exp); end
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        #1;
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL midrun_in_reset got=%b exp=%b", got, exp); end
        @(negedge clk);
        drive(4'b0000, 1'b0, 1'b0);
        #1;
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL midrun_resume got=%b exp=%b", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        logic [3:0] op;
        logic       c;
        logic       z;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(15));
            c  = 1'($urandom_range(1));
            z  = 1'($urandom_range(1));
            drive(op, c, z);
            #1;
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL back_to_back op=%b c=%0d z=%0d got=%b exp=%b", op, c, z, got, exp);
            end
            // Second change within the same cycle: no register stage in the path.
            op = ~op;
            drive(op, z, c);
            #1;
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL same_cycle op=%b got=%b exp=%b", op, got, exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        exp_run        = 1'b0;
        bus.opcode     = 4'b1111;
        bus.flag_carry = 1'b0;
        bus.flag_zero  = 1'b0;
        test_reset();
        test_sweep();
        test_cond_jumps();
        test_flag_independence();
        test_unassigned();
        test_midrun_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
